pcs_rx_decoder: RTL

64b/66b receive decoder for the 10G PCS RX path; counterpart of the TX encoder. Accepts descrambled 32-bit half-blocks plus sync header from the RX gearbox/block-lock stage and produces 32-bit XGMII RX data/control toward the MAC RX. Includes a simplified Clause-49 receive state machine that enforces frame ordering and replaces illegal sequences with error blocks.

---
 rtl/pcs_rx_decoder_if.sv | 26 ++
 rtl/pcs_rx_decoder.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pcs_rx_decoder_if.sv
// Receive-side bundle: gearbox half-blocks in, XGMII RX lanes out.
// Slave modport is the decoder's view; master is the upstream/sink side.
interface pcs_rx_decoder_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8,
    parameter int HDR_WIDTH  = 2
);
    logic [DATA_WIDTH-1:0] i_rx_data;
    logic [HDR_WIDTH-1:0]  i_rx_hdr;
    logic                  i_rx_hdr_valid;
    logic                  i_rx_data_valid;
    logic                  i_block_lock;
    logic [DATA_WIDTH-1:0] o_xgmii_rxd;
    logic [CTRL_WIDTH-1:0] o_xgmii_rxc;
    logic                  o_xgmii_rvalid;
    logic                  o_decode_err;

    modport master (
        output i_rx_data, i_rx_hdr, i_rx_hdr_valid, i_rx_data_valid, i_block_lock,
        input  o_xgmii_rxd, o_xgmii_rxc, o_xgmii_rvalid, o_decode_err
    );
    modport slave (
        input  i_rx_data, i_rx_hdr, i_rx_hdr_valid, i_rx_data_valid, i_block_lock,
        output o_xgmii_rxd, o_xgmii_rxc, o_xgmii_rvalid, o_decode_err
    );
endinterface

// File: rtl/pcs_rx_decoder.sv
// 64b/66b RX decoder with simplified receive FSM; latency 2 beats from block word1 to its lanes.
// No backpressure: gearbox pauses (i_rx_data_valid low) stall input and output together.
module pcs_rx_decoder #(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8,
    parameter int HDR_WIDTH  = 2
) (
    input  logic              i_rx_clk,
    input  logic              i_rx_reset,
    pcs_rx_decoder_if.slave   bus
);
    localparam int BLK_W = 2 * DATA_WIDTH;
    localparam int BLK_C = 2 * CTRL_WIDTH;
    localparam logic [BLK_W-1:0] IDLE_BLK = {BLK_C{8'h07}};
    localparam logic [BLK_W-1:0] ERR_BLK  = {BLK_C{8'hFE}};

    typedef enum logic [1:0] {RX_INIT, RX_C, RX_D, RX_E} rx_state_t;
    typedef enum logic [2:0] {CL_C, CL_S, CL_D, CL_T, CL_E} blk_class_t;

    rx_state_t             state_q, state_d;
    logic                  have_w0_q;
    logic [DATA_WIDTH-1:0] w0_q;
    logic [HDR_WIDTH-1:0]  hdr_q;
    logic [BLK_W-1:0]      blk_dat_q, blk_dat_d;
    logic [BLK_C-1:0]      blk_ctl_q, blk_ctl_d;
    logic                  blk_err_q;
    logic [DATA_WIDTH-1:0] rxd_q;
    logic [CTRL_WIDTH-1:0] rxc_q;
    logic                  rvalid_q;
    logic                  err_q;

    logic [BLK_W-1:0]      payload;
    logic [BLK_W-1:0]      rest;
    logic [7:0]            btype;
    logic [2:0]            term_k;
    logic                  is_term;
    blk_class_t            cls;

    assign payload = {bus.i_rx_data, w0_q};
    assign rest    = payload >> 8;
    assign btype   = payload[7:0];

    always_comb begin
        is_term = 1'b1;
        term_k  = 3'd0;
        case (btype)
            8'h87:   term_k = 3'd0;
            8'h99:   term_k = 3'd1;
            8'hAA:   term_k = 3'd2;
            8'hB4:   term_k = 3'd3;
            8'hCC:   term_k = 3'd4;
            8'hD2:   term_k = 3'd5;
            8'hE1:   term_k = 3'd6;
            8'hFF:   term_k = 3'd7;
            default: is_term = 1'b0;
        endcase
    end

    always_comb begin
        cls       = CL_E;
        blk_dat_d = ERR_BLK;
        blk_ctl_d = '1;
        if (hdr_q == 2'b01) begin
            cls       = CL_D;
            blk_dat_d = payload;
            blk_ctl_d = '0;
        end else if (hdr_q == 2'b10) begin
            if (btype == 8'h1E) begin
                cls = CL_C;
                // Idle codes become 0x07; the error code 0x1E stays 0xFE; anything else poisons the block.
                for (int i = 0; i < 8; i++) begin
                    if (payload[8+7*i +: 7] == 7'h00)
                        blk_dat_d[8*i +: 8] = 8'h07;
                    else if (payload[8+7*i +: 7] != 7'h1E)
                        cls = CL_E;
                end
            end else if (btype == 8'h78) begin
                cls       = CL_S;
                blk_dat_d = {payload[BLK_W-1:8], 8'hFB};
                blk_ctl_d = 8'h01;
            end else if (btype == 8'h33) begin
                cls       = CL_S;
                blk_dat_d = {payload[BLK_W-1:40], 8'hFB, 32'h07070707};
                blk_ctl_d = 8'h1F;
            end else if (is_term) begin
                cls = CL_T;
                for (int i = 0; i < 8; i++) begin
                    if (i < int'(term_k)) begin
                        blk_dat_d[8*i +: 8] = rest[8*i +: 8];
                        blk_ctl_d[i]        = 1'b0;
                    end else if (i == int'(term_k)) begin
                        blk_dat_d[8*i +: 8] = 8'hFD;
                    end else begin
                        blk_dat_d[8*i +: 8] = 8'h07;
                    end
                end
            end
        end
    end

    always_comb begin
        state_d = RX_E;
        if (state_q == RX_D) begin
            case (cls)
                CL_D:    state_d = RX_D;
                CL_T:    state_d = RX_C;
                default: state_d = RX_E;
            endcase
        end else begin
            case (cls)
                CL_C:    state_d = RX_C;
                CL_S:    state_d = RX_D;
                default: state_d = RX_E;
            endcase
        end
    end

    always_ff @(posedge i_rx_clk or posedge i_rx_reset) begin
        if (i_rx_reset) begin
            state_q   <= RX_INIT;
            have_w0_q <= 1'b0;
            w0_q      <= '0;
            hdr_q     <= '0;
            blk_dat_q <= IDLE_BLK;
            blk_ctl_q <= '1;
            blk_err_q <= 1'b0;
            rxd_q     <= {CTRL_WIDTH{8'h07}};
            rxc_q     <= '1;
            rvalid_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            rvalid_q <= bus.i_rx_data_valid;
            err_q    <= 1'b0;
            if (bus.i_rx_data_valid) begin
                if (!bus.i_block_lock) begin
                    state_q   <= RX_INIT;
                    have_w0_q <= 1'b0;
                    blk_dat_q <= IDLE_BLK;
                    blk_ctl_q <= '1;
                    blk_err_q <= 1'b0;
                    rxd_q     <= {CTRL_WIDTH{8'hFE}};
                    rxc_q     <= '1;
                end else if (bus.i_rx_hdr_valid) begin
                    w0_q      <= bus.i_rx_data;
                    hdr_q     <= bus.i_rx_hdr;
                    have_w0_q <= 1'b1;
                    if (have_w0_q) begin
                        // Truncated block: emit it as an error block in place of the pending lanes.
                        state_q   <= RX_E;
                        blk_dat_q <= ERR_BLK;
                        blk_ctl_q <= '1;
                        blk_err_q <= 1'b0;
                        rxd_q     <= {CTRL_WIDTH{8'hFE}};
                        rxc_q     <= '1;
                        err_q     <= 1'b1;
                    end else begin
                        rxd_q <= blk_dat_q[DATA_WIDTH-1:0];
                        rxc_q <= blk_ctl_q[CTRL_WIDTH-1:0];
                        err_q <= blk_err_q;
                    end
                end else begin
                    rxd_q <= blk_dat_q[BLK_W-1:DATA_WIDTH];
                    rxc_q <= blk_ctl_q[BLK_C-1:CTRL_WIDTH];
                    if (have_w0_q) begin
                        have_w0_q <= 1'b0;
                        state_q   <= state_d;
                        blk_dat_q <= (state_d == RX_E) ? ERR_BLK : blk_dat_d;
                        blk_ctl_q <= (state_d == RX_E) ? '1 : blk_ctl_d;
                        blk_err_q <= (state_d == RX_E);
                    end
                end
            end
        end
    end

    assign bus.o_xgmii_rxd    = rxd_q;
    assign bus.o_xgmii_rxc    = rxc_q;
    assign bus.o_xgmii_rvalid = rvalid_q;
    assign bus.o_decode_err   = err_q;
endmodule
